// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared definitions for the data-memory responder
//
// Holds the word width, the FSM state encoding, the legal latency range and
// the upper-address fault helper used by dmem_responder and its storage array.
package dmem_responder_pkg;

  localparam int WORD    = 16;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when any address bit above the implemented word index is set.
  function automatic logic addr_fault(input logic [WORD-1:0] addr, input int aw);
    return (addr >> aw) != '0;
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// rtl/dmem_responder_array.sv - DEPTH x 16 word storage for the data-memory responder
//
// Ports:
//   clk            clock, all updates on posedge
//   reset          synchronous active-high; clears the read register only
//   we/waddr/wdata synchronous write port
//   ren/raddr      registered read port; rdata loads mem[raddr] when ren
//   rzero          with ren, loads zero instead of memory (faulting read)
//   rdata          read register
// Parameter INITFILE: retained for interface compatibility; reset never
// touches the contents.
module dmem_responder_array
  import dmem_responder_pkg::*;
#(
  parameter int    AW       = 12,
  parameter string INITFILE = ""
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [WORD-1:0] wdata,
  input  logic            ren,
  input  logic [AW-1:0]   raddr,
  input  logic            rzero,
  output logic [WORD-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [WORD-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (ren) begin
      rdata <= rzero ? '0 : mem[raddr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - valid/ready data-memory responder with posted writes and fixed read latency
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   req_valid/req_ready        request handshake; one request at a time
//   req_write/req_addr/req_wdata  store (1) or load (0), word address, store data
//   rsp_valid/rsp_ready        read-response handshake
//   rsp_rdata/rsp_err          read data and address-fault flag, held until consumed
// Optional feature DMEM_ERR_EN: addresses with bits set above AW fault; faulting
// writes are dropped and faulting reads return zero with rsp_err=1. Without it
// the upper bits are ignored and the memory aliases modulo 2**AW.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int    AW       = 12,
  parameter int    LATENCY  = 3,
  parameter string INITFILE = ""
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [WORD-1:0] rsp_rdata,
  output logic            rsp_err
);

  generate
    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
      $error("dmem_responder: LATENCY out of range");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    addr_q;
  logic             err_q;

  logic             accept;
  logic             fault_now;
  logic             mem_we;
  logic             rd_load;
  logic [AW-1:0]    rd_addr;
  logic             rd_zero;

  // Reset gates the ready so that a handshake coinciding with reset is void.
  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

`ifdef DMEM_ERR_EN
  assign fault_now = addr_fault(req_addr, AW);
`else
  logic unused_addr_hi;
  assign fault_now      = 1'b0;
  assign unused_addr_hi = |(req_addr >> AW);
`endif

  assign mem_we = accept && req_write && !fault_now;

  // The counter is loaded with LATENCY-1 at acceptance and the response is
  // taken when it has run down to zero, so rsp_valid rises right after the
  // LATENCY-th edge following the accept. LATENCY==1 reads at the accept edge.
  assign rd_load = ((state == IDLE) && accept && !req_write && (LATENCY == 1)) ||
                   ((state == WAIT) && (cnt == '0));
  assign rd_addr = (state == IDLE) ? req_addr[AW-1:0] : addr_q;
  assign rd_zero = (state == IDLE) ? fault_now : err_q;

  dmem_responder_array #(
    .AW       (AW),
    .INITFILE (INITFILE)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (req_addr[AW-1:0]),
    .wdata (req_wdata),
    .ren   (rd_load),
    .raddr (rd_addr),
    .rzero (rd_zero),
    .rdata (rsp_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !req_write) begin
            addr_q <= req_addr[AW-1:0];
            err_q  <= fault_now;
            cnt    <= CNT_LOAD;
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= fault_now;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (LATENCY 3 and LATENCY 1 instances)
module tb_dmem_responder;

  localparam int AW    = 12;
  localparam int DEPTH = 2 ** AW;
`ifdef DMEM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;

  logic        r1_req_valid, r1_req_ready, r1_req_write;
  logic [15:0] r1_req_addr, r1_req_wdata;
  logic        r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
  logic [15:0] r1_rsp_rdata;

  dmem_responder #(.AW(AW), .LATENCY(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.AW(AW), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_write(r1_req_write),
    .req_addr(r1_req_addr), .req_wdata(r1_req_wdata),
    .rsp_valid(r1_rsp_valid), .rsp_ready(r1_rsp_ready),
    .rsp_rdata(r1_rsp_rdata), .rsp_err(r1_rsp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory: word index -> contents, plus the list of indices written.
  logic [15:0] model [int];
  int          widx [$];

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic bit m_fault(input logic [15:0] a);
    return ERR && ((int'(a) / DEPTH) != 0);
  endfunction

  task automatic m_write(input logic [15:0] a, input logic [15:0] d);
    if (!m_fault(a)) begin
      model[int'(a) % DEPTH] = d;
      widx.push_back(int'(a) % DEPTH);
    end
  endtask

  task automatic m_read(input logic [15:0] a, output logic [15:0] d, output bit e);
    if (m_fault(a)) begin
      d = 16'h0000;
      e = 1'b1;
    end else begin
      d = model[int'(a) % DEPTH];
      e = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
    m_write(a, d);
  endtask

  // Issues a load, measures edges from accept to rsp_valid, holds the response
  // for 'stall' cycles while pushing ignored junk requests, then consumes it.
  task automatic do_read(input logic [15:0] a, input int stall,
                         output logic [15:0] d, output logic e, output int lat);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = 16'($urandom);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 16'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    d = rsp_rdata;
    e = rsp_err;
    chk("rsp_req_ready_low", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1; req_write = 1'b1;
      req_addr = 16'($urandom_range(0, 15)); req_wdata = 16'($urandom);
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rdata", {16'd0, rsp_rdata}, {16'd0, d});
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0; req_write = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hs_rsp_valid_low", {31'd0, rsp_valid}, 32'd0);
    chk("hs_req_ready_high", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [10];
    logic [15:0] d, ed;
    logic        e;
    bit          ee;
    int          lat, cnt_v, k;

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    r1_req_valid = 1'b0; r1_req_write = 1'b0; r1_req_addr = '0; r1_req_wdata = '0;
    r1_rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready_held", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset1_req_ready", {31'd0, r1_req_ready}, 32'd1);
    chk("reset1_rsp_valid", {31'd0, r1_rsp_valid}, 32'd0);

    // Table: write/read pairs, back-to-back same-address read, address boundaries.
    vecs[0] = '{1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 16'h0009, 16'h0001, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 16'h0009, 16'h0000, 16'h0001, 1'b0};
    vecs[4] = '{1'b1, 16'h0007, 16'h7777, 16'h0000, 1'b0};
    vecs[5] = '{1'b1, 16'h0FFF, 16'hA5A5, 16'h0000, 1'b0};
    vecs[6] = '{1'b1, 16'h0000, 16'h5A5A, 16'h0000, 1'b0};
    vecs[7] = '{1'b0, 16'h0FFF, 16'h0000, 16'hA5A5, 1'b0};
    vecs[8] = '{1'b0, 16'h0000, 16'h0000, 16'h5A5A, 1'b0};
    vecs[9] = '{1'b0, 16'h0007, 16'h0000, 16'h7777, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        do_read(vecs[i].addr, 0, d, e, lat);
        chk($sformatf("vec%0d_rdata", i), {16'd0, d}, {16'd0, vecs[i].exp_rdata});
        chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
        chk($sformatf("vec%0d_latency", i), lat, 32'd3);
      end
    end

    // Long response stall on address 7.
    do_read(16'h0007, 4, d, e, lat);
    chk("stall_read_rdata", {16'd0, d}, 32'h7777);
    chk("stall_read_latency", lat, 32'd3);

    // Reset while a read is waiting: the response must never appear.
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0005;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midread_reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midread_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    cnt_v = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) cnt_v++;
    end
    chk("midread_no_response", cnt_v, 32'd0);
    do_read(16'h0005, 0, d, e, lat);
    chk("post_reset_addr5", {16'd0, d}, 32'hBEEF);

    // Upper-address handling: fault with DMEM_ERR_EN, alias without it.
    do_write(16'h1005, 16'h1234);
    do_read(16'h1005, 1, d, e, lat);
    chk("hi_addr_rdata", {16'd0, d}, ERR ? 32'h0000 : 32'h1234);
    chk("hi_addr_err", {31'd0, e}, ERR ? 32'd1 : 32'd0);
    chk("hi_addr_latency", lat, 32'd3);
    do_read(16'h0005, 0, d, e, lat);
    chk("addr5_after_hi", {16'd0, d}, ERR ? 32'hBEEF : 32'h1234);

    // LATENCY=1 instance: write then read the same word back to back.
    r1_req_valid = 1'b1; r1_req_write = 1'b1; r1_req_addr = 16'h0003; r1_req_wdata = 16'h3333;
    @(posedge clk); #1;
    r1_req_write = 1'b0; r1_req_wdata = 16'h0000;
    @(posedge clk); #1;
    r1_req_valid = 1'b0;
    k = 0;
    while (!r1_rsp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("lat1_latency", k, 32'd0);
    chk("lat1_rdata", {16'd0, r1_rsp_rdata}, 32'h3333);
    chk("lat1_req_ready_low", {31'd0, r1_req_ready}, 32'd0);
    r1_rsp_ready = 1'b1;
    @(posedge clk); #1;
    r1_rsp_ready = 1'b0;
    chk("lat1_hs_rsp_valid", {31'd0, r1_rsp_valid}, 32'd0);
    chk("lat1_hs_req_ready", {31'd0, r1_req_ready}, 32'd1);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 250; i++) begin
      logic [15:0] a, up;
      up = ($urandom_range(0, 3) == 0) ? (16'($urandom_range(1, 15)) << AW) : 16'h0000;
      if (widx.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = 16'($urandom_range(0, DEPTH - 1)) | up;
        do_write(a, 16'($urandom));
      end else begin
        a = 16'(widx[$urandom_range(0, widx.size() - 1)]) | up;
        m_read(a, ed, ee);
        do_read(a, $urandom_range(0, 2), d, e, lat);
        chk($sformatf("rnd%0d_rdata@%0h", i, a), {16'd0, d}, {16'd0, ed});
        chk($sformatf("rnd%0d_err", i), {31'd0, e}, {31'd0, ee});
        chk($sformatf("rnd%0d_latency", i), lat, 32'd3);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
